cam_pixel_capture: RTL
======================

Name: cam_pixel_capture

Overview:
- Downstream stage of the OV7670 camera interface; runs in the Pclk domain.
- Turns the raw byte stream (data, Href, Vsyn) into one RGB332 pixel per byte pair, with a linear frame-buffer write address and write strobe.
- Frames the capture: arms on capture_en, starts at frame start, and reports frame completion/validity to the Rubik colour-sampling logic.

Parameters:
- H_PIX, 160, pixels per line stored.
- V_LINES, 120, lines per frame stored.
- AW, 15, address width; must satisfy 2^AW >= H_PIX*V_LINES.

Ports:
- Pclk  in  1  camera pixel clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- capture_en  in  1  level; arms capture of the next full frame.
- Vsyn  in  1  camera VSYNC; high = vertical blanking.
- Href  in  1  camera HREF; high = valid bytes on data.
- data  in  8  camera byte, RGB565, first byte = {R[4:0],G[5:3]}.
- px_data  out  8  RGB332 pixel {R[4:2],G[5:3],B[4:3]}.
- px_addr  out  AW  frame-buffer write address.
- px_we  out  1  write strobe, one Pclk per pixel.
- frame_done  out  1  one-cycle pulse at end of captured frame.
- frame_ok  out  1  registered; 1 if last frame had exactly H_PIX*V_LINES pixels and no line errors.
- busy  out  1  high in WAIT_VS and CAPTURE.

Behaviour:
- Reset (rst=0, async): state=IDLE; px_data=0, px_addr=0, px_we=0, frame_done=0, frame_ok=0, busy=0; byte phase=0; line counter=0; error flag=0.
- Inputs are sampled on posedge Pclk. Vsyn and Href are registered once; edges are detected on the registered copies.
- FSM states:
  - IDLE -> WAIT_VS when capture_en=1.
  - WAIT_VS: wait for registered Vsyn falling edge (frame start). Clear px_addr, line count and error flag -> CAPTURE. If capture_en=0 while waiting -> IDLE.
  - CAPTURE: assemble pixels. Registered Vsyn rising edge -> DONE.
  - DONE: single cycle. frame_done=1; frame_ok updated. Then -> WAIT_VS if capture_en=1, else IDLE.
- Dropping capture_en mid-frame does not abort the frame; the current frame completes, then the FSM goes to IDLE.
- Pixel assembly while in CAPTURE with Href=1:
  - phase 0 latches the high byte.
  - phase 1 forms the pixel; px_we=1 on the next cycle, with px_data/px_addr valid in the same cycle as px_we.
  - Latency: second byte sample to px_we = 1 Pclk.
  - px_addr increments after each write.
- Href falling edge ends a line: line count +1 and phase reset to 0. If phase was 1 (odd byte count), the half pixel is discarded and the error flag is set.
- Overflow: once the pixel count reaches H_PIX*V_LINES, further pixels are dropped (no px_we), px_addr holds at H_PIX*V_LINES-1, and the error flag is set. Short frames (fewer pixels at Vsyn rise) give frame_ok=0.
- Simultaneous Vsyn rise and a pending pixel write: the write completes, and DONE follows it.
- px_we is never asserted outside CAPTURE.

Optional Feature:
- Macro CAM_DECIMATE_EN.
  - Defined: 2:1 decimation in both axes. Only even pixels of even lines are written, so a 320x240 QVGA stream fills H_PIX x V_LINES. Decimation counters reset at each line/frame start. The line error check still applies on every line.
  - Undefined: every pixel of every line is written. The camera is configured to output H_PIX x V_LINES directly.

Decomposition:
- Package cam_pkg holds:
  - FSM state encoding (IDLE, WAIT_VS, CAPTURE, DONE).
  - Localparam FRAME_PIX = H_PIX*V_LINES.
  - The RGB565->RGB332 packing function.
- One natural sub-module: cam_sync_edge, which registers Vsyn/Href and emits rise/fall pulses.

Test Plan:
- Reset mid-CAPTURE (rst low for 1 cycle at pixel 500) -> all outputs 0, state IDLE, no px_we until a new Vsyn falling edge with capture_en=1.
- Full 160x120 frame, bytes 0xF8,0x1F repeating -> 19200 px_we pulses, px_data=0xE3, last px_addr=19199, frame_done one cycle after the Vsyn rise, frame_ok=1.
- Line 5 with 319 bytes (odd) -> 159 writes on that line, half pixel dropped, frame_ok=0 at frame_done.
- 121 lines of 160 pixels -> writes stop at 19200, px_addr holds at 19199, frame_ok=0.
- capture_en dropped at line 60 -> frame completes, frame_done pulses, state returns to IDLE, next frame ignored (no px_we).
- With CAM_DECIMATE_EN: 320x240 stream -> exactly 19200 writes, pixel at addr 1 sourced from input pixel 2 of line 0.

Source files
------------

// File: rtl/cam_pkg.sv
// cam_pkg: capture FSM encoding, default frame geometry and the RGB565 -> RGB332
// packing shared by the OV7670 pixel-capture stage.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cam_state_e;

  localparam int H_PIX_DEF   = 160;
  localparam int V_LINES_DEF = 120;
  localparam int FRAME_PIX   = H_PIX_DEF * V_LINES_DEF;

  // hi = {R[4:0],G[5:3]}, lo = {G[2:0],B[4:0]}; keep the top bits of each channel
  function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: registers camera Vsyn/Href once and derives one-cycle
// rise/fall pulses from the registered copies.
module cam_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vsyn,
  input  logic i_href,
  output logic o_vs_rise,
  output logic o_vs_fall,
  output logic o_href_fall
);

  logic r_vs;
  logic r_vs_d;
  logic r_href;
  logic r_href_d;

  // Input register plus one cycle of history for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs     <= 1'b0;
      r_vs_d   <= 1'b0;
      r_href   <= 1'b0;
      r_href_d <= 1'b0;
    end else begin
      r_vs     <= i_vsyn;
      r_vs_d   <= r_vs;
      r_href   <= i_href;
      r_href_d <= r_href;
    end
  end

  assign o_vs_rise   = r_vs & ~r_vs_d;
  assign o_vs_fall   = ~r_vs & r_vs_d;
  assign o_href_fall = ~r_href & r_href_d;

endmodule

// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: frames OV7670 RGB565 byte pairs into RGB332 frame-buffer writes.
// Optional 2:1 decimation in both axes when CAM_DECIMATE_EN is defined.
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int H_PIX   = H_PIX_DEF,
  parameter int V_LINES = V_LINES_DEF,
  parameter int AW      = 15
) (
  input  logic          Pclk,
  input  logic          rst,
  input  logic          capture_en,
  input  logic          Vsyn,
  input  logic          Href,
  input  logic [7:0]    data,
  output logic [7:0]    px_data,
  output logic [AW-1:0] px_addr,
  output logic          px_we,
  output logic          frame_done,
  output logic          frame_ok,
  output logic          busy
);

  localparam int          FRAME_INT = H_PIX * V_LINES;
  localparam logic [AW:0] FRAME_N   = FRAME_INT[AW:0];

  cam_state_e    r_state;
  logic          r_phase;
  logic [7:0]    r_hi;
  logic [AW:0]   r_pix_cnt;
  logic [9:0]    r_line_cnt;
  logic          r_err;
  logic          r_vs_pend;
  logic [7:0]    r_px_data;
  logic [AW-1:0] r_px_addr;
  logic          r_px_we;
  logic          r_frame_done;
  logic          r_frame_ok;
  logic          r_busy;

  logic w_vs_rise;
  logic w_vs_fall;
  logic w_href_fall;
  logic w_form;
  logic w_keep;

  cam_sync_edge u_sync (
    .i_clk       (Pclk),
    .i_rst_n     (rst),
    .i_vsyn      (Vsyn),
    .i_href      (Href),
    .o_vs_rise   (w_vs_rise),
    .o_vs_fall   (w_vs_fall),
    .o_href_fall (w_href_fall)
  );

`ifdef CAM_DECIMATE_EN
  logic r_col;
  assign w_keep = ~r_col & ~r_line_cnt[0];
`else
  assign w_keep = 1'b1;
`endif

  // A second byte arriving this cycle completes a pixel (written or dropped)
  assign w_form = Href & r_phase & ~r_vs_pend;

  // Capture FSM with pixel assembly and registered outputs
  always_ff @(posedge Pclk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_phase      <= 1'b0;
      r_hi         <= 8'd0;
      r_pix_cnt    <= '0;
      r_line_cnt   <= 10'd0;
      r_err        <= 1'b0;
      r_vs_pend    <= 1'b0;
      r_px_data    <= 8'd0;
      r_px_addr    <= '0;
      r_px_we      <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_busy       <= 1'b0;
`ifdef CAM_DECIMATE_EN
      r_col        <= 1'b0;
`endif
    end else begin
      r_px_we      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= capture_en;
          if (capture_en) begin
            r_state <= ST_WAIT_VS;
          end
        end
        ST_WAIT_VS: begin
          if (!capture_en) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_vs_fall) begin
            r_state    <= ST_CAPTURE;
            r_px_addr  <= '0;
            r_pix_cnt  <= '0;
            r_line_cnt <= 10'd0;
            r_err      <= 1'b0;
            r_phase    <= 1'b0;
            r_vs_pend  <= 1'b0;
`ifdef CAM_DECIMATE_EN
            r_col      <= 1'b0;
`endif
          end
        end
        ST_CAPTURE: begin
          if (Href && !r_vs_pend) begin
            if (!r_phase) begin
              r_hi    <= data;
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
`ifdef CAM_DECIMATE_EN
              r_col   <= ~r_col;
`endif
              if (w_keep) begin
                if (r_pix_cnt < FRAME_N) begin
                  r_px_data <= rgb565_to_332(r_hi, data);
                  r_px_addr <= r_pix_cnt[AW-1:0];
                  r_px_we   <= 1'b1;
                  r_pix_cnt <= r_pix_cnt + {{AW{1'b0}}, 1'b1};
                end else begin
                  r_err <= 1'b1;
                end
              end
            end
          end else if (w_href_fall) begin
            r_phase    <= 1'b0;
            r_line_cnt <= r_line_cnt + 10'd1;
`ifdef CAM_DECIMATE_EN
            r_col      <= 1'b0;
`endif
            if (r_phase) begin
              r_err <= 1'b1;
            end
          end
          // A pixel completing alongside the Vsyn rise is finished before DONE
          if (w_vs_rise || r_vs_pend) begin
            if (w_form) begin
              r_vs_pend <= 1'b1;
            end else begin
              r_vs_pend    <= 1'b0;
              r_state      <= ST_DONE;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
              r_frame_ok   <= (r_pix_cnt == FRAME_N) && !r_err && !(w_href_fall && r_phase);
            end
          end
        end
        ST_DONE: begin
          r_busy <= capture_en;
          if (capture_en) begin
            r_state <= ST_WAIT_VS;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign px_data    = r_px_data;
  assign px_addr    = r_px_addr;
  assign px_we      = r_px_we;
  assign frame_done = r_frame_done;
  assign frame_ok   = r_frame_ok;
  assign busy       = r_busy;

endmodule
